// File: rtl/predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module : predictor_pkg
// Brief  : Constants shared by the 2-bit predictor and its outcome tracker.
// Rev    : 1.0
// ============================================================================
package predictor_pkg;
    localparam int COUNTER_BITS = 2;
    localparam int TRACK_DEPTH  = 4;
    localparam int STAT_WIDTH   = 16;
endpackage
`default_nettype wire

// File: rtl/branch_fifo.sv
`default_nettype none
// ============================================================================
// Module : branch_fifo
// Brief  : 1-bit circular buffer of in-flight predictions with sync flush.
// Rev    : 1.0
// ============================================================================
module branch_fifo
    import predictor_pkg::*;
#(
    parameter int DEPTH = TRACK_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         push_data_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         head_data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic          mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          w_pop;
    logic          w_push;

    // Pops on an empty buffer are ignored; the push in that cycle still lands.
    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && ((count_q != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) tail_q <= tail_q + PW'(1);
            if (w_pop)  head_q <= head_q + PW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && w_push) mem_q[tail_q] <= push_data_i;
    end

    assign count_o     = count_q;
    assign head_data_o = mem_q[head_q];
endmodule
`default_nettype wire

// File: rtl/branch_outcome_tracker.sv
`default_nettype none
// ============================================================================
// Module : branch_outcome_tracker
// Brief  : Queues predictions, checks them at resolve, drives update strobes.
// Rev    : 1.0
// ============================================================================
module branch_outcome_tracker
    import predictor_pkg::*;
#(
    parameter int DEPTH     = TRACK_DEPTH,
    parameter int CNT_WIDTH = STAT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         request,
    input  logic                         prediction,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    output logic                         result,
    output logic                         taken,
    output logic                         mispredict,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic [CNT_WIDTH-1:0]         branch_count,
    output logic [CNT_WIDTH-1:0]         mispredict_count,
    output logic                         underflow
);
    localparam int CW = $clog2(DEPTH+1);

    logic                 req_q, req_d;
    logic                 result_q, result_d;
    logic                 taken_q, taken_d;
    logic                 mispredict_q, mispredict_d;
    logic                 underflow_q, underflow_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    logic [CW-1:0]        w_count;
    logic                 w_head;
    logic                 w_nonempty;
    logic                 w_pop_ok;
    logic                 w_mis;
    logic [CW:0]          w_occ_sum;

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (w_mis),
        .push_i      (req_q),
        .push_data_i (prediction),
        .pop_i       (resolve_valid),
        .count_o     (w_count),
        .head_data_o (w_head)
    );

    assign w_nonempty = (w_count != '0);
    assign w_pop_ok   = resolve_valid && w_nonempty;
    assign w_mis      = w_pop_ok && (w_head != resolve_taken);

    // A captured request still to land counts against capacity.
    assign w_occ_sum  = {1'b0, w_count} + {{CW{1'b0}}, req_q};
    assign stall      = (w_occ_sum >= (CW+1)'(DEPTH));

    always_comb begin
        req_d        = w_mis ? 1'b0 : (request && !stall);
        result_d     = w_pop_ok;
        taken_d      = w_pop_ok && resolve_taken;
        mispredict_d = w_mis;
        underflow_d  = underflow_q || (resolve_valid && !w_nonempty);
        br_cnt_d     = br_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (w_pop_ok && (br_cnt_q != '1)) br_cnt_d  = br_cnt_q + CNT_WIDTH'(1);
        if (w_mis && (mis_cnt_q != '1))   mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q        <= 1'b0;
            result_q     <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
            br_cnt_q     <= '0;
            mis_cnt_q    <= '0;
        end else begin
            req_q        <= req_d;
            result_q     <= result_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
            br_cnt_q     <= br_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign result           = result_q;
    assign taken            = taken_q;
    assign mispredict       = mispredict_q;
    assign underflow        = underflow_q;
    assign outstanding      = w_count;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;
endmodule
`default_nettype wire

// File: doc/branch_outcome_tracker.md
# branch_outcome_tracker

Tracks in-flight branch predictions between the fetch-side predictor and the execute-stage branch unit. Each prediction produced by the 2-bit saturating predictor is queued in order. When the branch resolves, the oldest entry is compared with the actual outcome, the predictor's `result`/`taken` update inputs are driven, and a mispredict pulse flushes the queue. Saturating branch and mispredict statistics counters are also kept.

## Interface
- `DEPTH`, 4: maximum outstanding predictions; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the statistics counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `request` in 1: fetch asks for a prediction; the same wire feeds the predictor.
- `prediction` in 1: predictor output; valid the cycle after `request`.
- `resolve_valid` in 1: execute resolves the oldest outstanding branch.
- `resolve_taken` in 1: actual direction of that branch.
- `result` out 1: one-cycle update strobe to the predictor.
- `taken` out 1: actual direction accompanying `result`.
- `mispredict` out 1: one-cycle pulse; stored prediction ≠ actual direction.
- `stall` out 1: fetch must hold `request` low.
- `outstanding` out $clog2(DEPTH+1): current queue occupancy.
- `branch_count` out CNT_WIDTH: resolved branches, saturating.
- `mispredict_count` out CNT_WIDTH: mispredictions, saturating.
- `underflow` out 1: sticky flag; a resolve arrived with nothing outstanding.

## Operation
- **Capture.** `req_d <= request & ~stall`. In a cycle with `req_d=1`, `prediction` is pushed at the tail.
- **Stall.** `stall = (outstanding + req_d) >= DEPTH`. This is combinational from registered state only.
  - If `request` is high while `stall` is high, the request is ignored. It is not captured and nothing is pushed.
- **Resolve.** When `resolve_valid=1` and the queue is non-empty, the head entry is popped.
  - Next cycle: `result=1`, `taken=resolve_taken`, `branch_count+1`.
  - If the stored bit ≠ `resolve_taken`: also `mispredict=1` and `mispredict_count+1`.
- **Mispredict flush.** At the resolving edge, head = tail = 0 and `outstanding=0`. `req_d` is cleared, and any push in that same cycle is dropped.
- **Underflow.** A resolve on an empty queue produces no `result`, `mispredict` or count change. It sets `underflow`, which is cleared only by `reset`.
- **Push and pop together.**
  - Both occur and `outstanding` is unchanged.
  - If the queue is empty in that cycle, the pop counts as underflow and the push still lands.
- **Pointers.** Head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. Fullness comes from `outstanding`, not from pointer equality.
- **Counters.** Both hold at all-ones. No wrap.
- **State.** Per-entry state is implicit (valid = within `outstanding`). There is no explicit FSM beyond `req_d`, the pointers and occupancy.

## Timing
- **Reset values.** `result`, `taken`, `mispredict`, `underflow`, `outstanding`, both counters and `req_d` are 0. `stall` is 0. The queue is empty.
- **Reset mid-operation.** All entries are discarded. Outputs read reset values the cycle after the reset edge, and no update strobe is emitted for discarded entries.
- **Latencies.**
  - `request` → entry pushed at edge t+2 (`req_d` at t+1, push at t+2).
  - `resolve_valid` at t → `result`/`taken`/`mispredict` high during t+1 only.
- **Registered outputs.** `result`, `taken`, `mispredict`, `outstanding`, the counters and `underflow` are all registered.

## Structure
- **Shared package `predictor_pkg`.** Holds `COUNTER_BITS` (2, shared with the predictor) and the default `TRACK_DEPTH`=4 and `STAT_WIDTH`=16.
- **Sub-module `branch_fifo`.** A 1-bit-wide circular buffer with push, pop, synchronous flush, `count` and `head_data`. The top level adds `req_d`, the compare, the strobes, the counters and `underflow`.

## Test plan
- **Reset:** pulse `reset` with `request` high → all outputs 0 next cycle and no push for 2 cycles after release.
- **Fill/stall:** DEPTH=4, request on 4 consecutive cycles with prediction=1 → `outstanding` reaches 4 and `stall`=1. A 5th request while stalled → no push, `outstanding` stays 4.
- **Correct resolve:** 4 entries of 1, resolve_taken=1 ×4 → `result`=1 for 4 cycles, `taken`=1, `mispredict`=0, `branch_count`=4, `mispredict_count`=0, `outstanding`=0.
- **Mispredict flush:** push 1,1,1, then resolve_taken=0 with `req_d`=1 in the same cycle → `mispredict`=1 next cycle, `outstanding`=0, the new push is dropped, `mispredict_count`=1.
- **Underflow and simultaneous events:** resolve on empty with a push landing → `underflow`=1, `result`=0, `outstanding`=1. With `outstanding`=2, simultaneous push/pop ×6 → occupancy stays 2, pointers wrap, FIFO order is preserved.
- **Saturation:** CNT_WIDTH=2, 5 mispredicting resolves → both counters hold at 3.
